// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: two-requester round-robin OBI arbiter with an in-order
// response ID FIFO. Requester 0 is the instruction-write bridge, requester 1
// the readback port. Request channel is a zero-latency mux; responses are
// routed back using the FIFO of granted requester IDs.
module obi_rr_arbiter #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        s0_req,
    input  logic        s0_we,
    input  logic [3:0]  s0_be,
    input  logic [31:0] s0_addr,
    input  logic [31:0] s0_wdata,
    output logic        s0_gnt,
    output logic        s0_rvalid,

    input  logic        s1_req,
    input  logic        s1_we,
    input  logic [3:0]  s1_be,
    input  logic [31:0] s1_addr,
    input  logic [31:0] s1_wdata,
    output logic        s1_gnt,
    output logic        s1_rvalid,

    output logic [31:0] s_rdata,

    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,

    output logic [2:0]  outstanding,
    output logic        busy,
    output logic        resp_err
);

    // Pointer width is at least 1; the storage is rounded up to a power of
    // two so any pointer value indexes a real entry, but pointers only ever
    // walk 0..MAX_OUTST-1.
    localparam int unsigned     PW       = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned     DEPTH    = 1 << PW;
    localparam logic [2:0]      MAX_CNT  = 3'(MAX_OUTST);
    localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_OUTST - 1);

    logic              lock_q;
    logic              lock_sel_q;
    logic              last_gnt_q;
    logic [DEPTH-1:0]  id_fifo_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [2:0]        cnt_q;
    logic              resp_err_q;

    logic              lock_live;
    logic              sel;
    logic              not_full;
    logic              req_int;
    logic              push;
    logic              pop;
    logic              head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Requester selection: a pending lock wins while its owner still
    // requests; otherwise a lone requester wins, and a tie goes to the one
    // not granted last.
    always_comb begin
        lock_live = lock_q & (lock_sel_q ? s1_req : s0_req);
        sel       = ~last_gnt_q;
        if (lock_live) begin
            sel = lock_sel_q;
        end else if (s0_req ^ s1_req) begin
            sel = s1_req;
        end
    end

    // Handshake qualification. Fullness uses the registered count, so a pop
    // in the same cycle only frees the slot for the following cycle.
    always_comb begin
        not_full = (cnt_q < MAX_CNT);
        req_int  = rst_n & (s0_req | s1_req) & not_full;
        push     = req_int & m_gnt;
        pop      = rst_n & m_rvalid & (cnt_q != 3'd0);
        head     = id_fifo_q[rptr_q];
    end

    // Request channel mux and response routing.
    always_comb begin
        m_req     = req_int;
        m_we      = sel ? s1_we    : s0_we;
        m_be      = sel ? s1_be    : s0_be;
        m_addr    = sel ? s1_addr  : s0_addr;
        m_wdata   = sel ? s1_wdata : s0_wdata;
        s0_gnt    = push & ~sel;
        s1_gnt    = push &  sel;
        s0_rvalid = pop & ~head;
        s1_rvalid = pop &  head;
        s_rdata   = m_rdata;
        outstanding = cnt_q;
        busy      = rst_n & ((cnt_q != 3'd0) | req_int);
        resp_err  = resp_err_q;
    end

    // Lock holds the selection across an ungranted request; any cycle
    // without a pending ungranted request (grant, drop, full) releases it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            lock_q     <= req_int & ~m_gnt;
            lock_sel_q <= sel;
        end
    end

    // Round-robin history and ID FIFO write side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            id_fifo_q  <= '0;
            wptr_q     <= '0;
        end else if (push) begin
            last_gnt_q        <= sel;
            id_fifo_q[wptr_q] <= sel;
            wptr_q            <= ptr_inc(wptr_q);
        end
    end

    // ID FIFO read side and outstanding count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q <= '0;
            cnt_q  <= 3'd0;
        end else begin
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky error for responses arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_err_q <= 1'b0;
        end else if (m_rvalid && (cnt_q == 3'd0)) begin
            resp_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter (MAX_OUTST = 2). Inputs change 1 ns
// after each rising edge; outputs are sampled 1 ns later.
module tb_obi_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_req, s0_we, s1_req, s1_we;
    logic [3:0]  s0_be, s1_be;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic        s0_gnt, s0_rvalid, s1_gnt, s1_rvalid;
    logic [31:0] s_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic [2:0]  outstanding;
    logic        busy, resp_err;

    int n_chk  = 0;
    int n_fail = 0;

    obi_rr_arbiter #(.MAX_OUTST(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_req(s0_req), .s0_we(s0_we), .s0_be(s0_be), .s0_addr(s0_addr),
        .s0_wdata(s0_wdata), .s0_gnt(s0_gnt), .s0_rvalid(s0_rvalid),
        .s1_req(s1_req), .s1_we(s1_we), .s1_be(s1_be), .s1_addr(s1_addr),
        .s1_wdata(s1_wdata), .s1_gnt(s1_gnt), .s1_rvalid(s1_rvalid),
        .s_rdata(s_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .outstanding(outstanding), .busy(busy), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s0_req = 0; s0_we = 0; s0_be = 4'hF; s0_addr = 32'h400; s0_wdata = 32'hAAAA0000;
        s1_req = 0; s1_we = 0; s1_be = 4'h3; s1_addr = 32'h300; s1_wdata = 32'hBBBB1111;
        m_gnt = 0; m_rvalid = 0; m_rdata = 32'h0;
    endtask

    initial begin
        // Reset with hostile inputs: everything must stay quiet
        idle();
        rst_n = 0; s0_req = 1; m_gnt = 1; m_rvalid = 1;
        cyc(); cyc();
        chk("rst_m_req", m_req, 0);
        chk("rst_s0_gnt", s0_gnt, 0);
        chk("rst_s0_rvalid", s0_rvalid, 0);
        chk("rst_s1_rvalid", s1_rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outst", outstanding, 0);
        chk("rst_resp_err", resp_err, 0);
        idle(); rst_n = 1; #1;
        chk("post_rst_busy", busy, 0);

        // Simultaneous requests: s0 wins first tie, then s1
        s0_req = 1; s1_req = 1; s0_addr = 32'h100; s1_addr = 32'h200; m_gnt = 1; #1;
        chk("tie0_s0_gnt", s0_gnt, 1);
        chk("tie0_s1_gnt", s1_gnt, 0);
        chk("tie0_addr", m_addr, 32'h100);
        cyc();
        chk("tie1_s1_gnt", s1_gnt, 1);
        chk("tie1_s0_gnt", s0_gnt, 0);
        chk("tie1_addr", m_addr, 32'h200);
        chk("tie1_outst", outstanding, 1);
        cyc();
        chk("full_outst", outstanding, 2);
        chk("full_m_req", m_req, 0);
        chk("full_s0_gnt", s0_gnt, 0);
        chk("full_busy", busy, 1);
        s0_req = 0; s1_req = 0; m_gnt = 0; m_rvalid = 1; #1;
        chk("drain0_s0_rvalid", s0_rvalid, 1);
        chk("drain0_s1_rvalid", s1_rvalid, 0);
        cyc();
        chk("drain1_s1_rvalid", s1_rvalid, 1);
        chk("drain1_outst", outstanding, 1);
        cyc(); m_rvalid = 0; #1;
        chk("drain_done", outstanding, 0);

        // Lock: s1 waits for gnt, s0 arrives in cycle 1, s1 keeps the bus
        idle(); s1_req = 1; s1_we = 1; #1;
        chk("lock0_m_req", m_req, 1);
        chk("lock0_s1_gnt", s1_gnt, 0);
        chk("lock0_addr", m_addr, 32'h300);
        chk("lock0_we", m_we, 1);
        chk("lock0_be", m_be, 4'h3);
        cyc(); s0_req = 1; #1;
        chk("lock1_addr", m_addr, 32'h300);
        cyc();
        chk("lock2_addr", m_addr, 32'h300);
        cyc(); m_gnt = 1; #1;
        chk("lock3_s1_gnt", s1_gnt, 1);
        chk("lock3_s0_gnt", s0_gnt, 0);
        cyc(); s1_req = 0; #1;
        chk("lock4_s0_gnt", s0_gnt, 1);
        chk("lock4_addr", m_addr, 32'h400);
        chk("lock4_we", m_we, 0);
        chk("lock4_wdata", m_wdata, 32'hAAAA0000);
        // In-order responses: s1 then s0
        cyc(); s0_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; #1;
        chk("ord0_s1_rvalid", s1_rvalid, 1);
        chk("ord0_s0_rvalid", s0_rvalid, 0);
        chk("ord0_rdata", s_rdata, 32'hDEADBEEF);
        cyc(); m_rdata = 32'h12345678; #1;
        chk("ord1_s0_rvalid", s0_rvalid, 1);
        chk("ord1_s1_rvalid", s1_rvalid, 0);
        chk("ord1_rdata", s_rdata, 32'h12345678);
        cyc(); m_rvalid = 0; #1;
        chk("ord_done", outstanding, 0);

        // Three back-to-back s0 writes against MAX_OUTST = 2
        idle(); s0_req = 1; s0_we = 1; m_gnt = 1; #1;
        chk("w0_gnt", s0_gnt, 1);
        cyc();
        chk("w1_gnt", s0_gnt, 1);
        cyc();
        chk("w2_outst", outstanding, 2);
        chk("w2_blocked", s0_gnt, 0);
        m_rvalid = 1; #1;
        chk("w2_rvalid", s0_rvalid, 1);
        chk("w2_pop_no_req", m_req, 0);
        cyc(); m_rvalid = 0; #1;
        chk("w3_outst", outstanding, 1);
        chk("w3_gnt", s0_gnt, 1);
        cyc(); s0_req = 0; #1;
        chk("w4_outst", outstanding, 2);

        // Grant and response in the same cycle at outstanding = 1
        m_rvalid = 1; #1;
        chk("gr0_s0_rvalid", s0_rvalid, 1);
        cyc(); s1_req = 1; #1;
        chk("gr1_outst", outstanding, 1);
        chk("gr1_s0_rvalid", s0_rvalid, 1);
        chk("gr1_s1_rvalid", s1_rvalid, 0);
        chk("gr1_s1_gnt", s1_gnt, 1);
        cyc(); s1_req = 0; m_gnt = 0; #1;
        chk("gr2_outst", outstanding, 1);
        chk("gr2_s1_rvalid", s1_rvalid, 1);
        cyc(); m_rvalid = 0; #1;
        chk("gr3_outst", outstanding, 0);
        chk("gr3_busy", busy, 0);

        // Stray response sets the sticky error; reset clears it
        m_rvalid = 1; #1;
        chk("stray_s0_rvalid", s0_rvalid, 0);
        chk("stray_s1_rvalid", s1_rvalid, 0);
        cyc(); m_rvalid = 0; #1;
        chk("stray_err", resp_err, 1);
        chk("stray_outst", outstanding, 0);
        cyc();
        chk("stray_sticky", resp_err, 1);
        rst_n = 0;
        cyc(); rst_n = 1; #1;
        chk("stray_err_clr", resp_err, 0);

        // Lock released when the locked requester withdraws
        idle(); s0_req = 1; #1;
        chk("drop0_addr", m_addr, 32'h400);
        cyc(); s0_req = 0; s1_req = 1; #1;
        chk("drop1_addr", m_addr, 32'h300);
        chk("drop1_m_req", m_req, 1);
        m_gnt = 1; #1;
        chk("drop1_s1_gnt", s1_gnt, 1);

        // Reset mid-transaction discards the ID; the late response is stray
        cyc(); s1_req = 0; m_gnt = 0; rst_n = 0;
        cyc(); rst_n = 1; m_rvalid = 1; #1;
        chk("mid_rst_s1_rvalid", s1_rvalid, 0);
        chk("mid_rst_outst", outstanding, 0);
        cyc(); m_rvalid = 0; #1;
        chk("mid_rst_err", resp_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
